uart_rx_block: RTL and testbench

Byte-oriented UART receiver: 8N1 framing, LSB first, line idle high. It sits on the inbound side of the UART link, directly downstream of the serial line driven by `uart_tx_block`. It oversamples the line on the system clock, validates the start bit, samples each data bit at mid-bit and checks the stop bit. It then presents the byte with a one-cycle valid strobe, or flags a framing error.

---
 rtl/uart_rx_block_if.sv | 25 ++
 rtl/uart_rx_block.sv | 142 ++++++++++++++
 tb/tb_uart_rx_block.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_block_if.sv
// Serial-in / byte-out signal bundle for uart_rx_block.
// The slave side is the receiver; the master side drives the line and consumes bytes.
interface uart_rx_block_if;
    logic       rx_in;
    logic [7:0] data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    modport master (
        output rx_in,
        input  data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err
    );

    modport slave (
        input  rx_in,
        output data,
        output rx_valid,
        output rx_busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with framing-error detection.
// Optional UART_RX_MAJORITY_EN: bit samples take a 3-sample majority of the synced line.
module uart_rx_block #(
    parameter int unsigned CLK_FREQ  = 44_000_000,
    parameter int unsigned BAUD_RATE = 230_400
) (
    input logic            clk,
    input logic            rst,
    uart_rx_block_if.slave rx
);
    localparam int unsigned CLK_COUNT = CLK_FREQ / BAUD_RATE + 1;
    localparam int unsigned HALF      = CLK_COUNT / 2;
    localparam int unsigned CNT_W     = $clog2(CLK_COUNT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e           state_q;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;
    logic             sample;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] tracks rx_sync_q; [1] and [2] are the two previous synced values.
    logic [2:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], rx_meta_q};
        end
    end

    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
    assign sample = rx_sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx.rx_in;
            rx_sync_q <= rx_meta_q;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Start detection always uses the raw synced line.
                    if (!rx_sync_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_MID) begin
                        if (!sample) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_q <= {sample, shift_q[7:1]};
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CNT_LAST) begin
                        if (sample) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    // A held-low line must go high before a new start is accepted.
                    if (rx_sync_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.data      = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.rx_busy   = busy_q;
    assign rx.frame_err = err_q;

endmodule

// File: tb/tb_uart_rx_block.sv
// Randomized self-checking bench for uart_rx_block against an ideal line-sampling model.
module tb_uart_rx_block;
    localparam int CC       = 44_000_000 / 230_400 + 1;
    localparam int HALF     = CC / 2;
    localparam int LINE_MAX = 80000;

    typedef struct {
        logic       valid;
        logic       err;
        int         ev_cyc;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic line [LINE_MAX];
    ev_t  evq[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx_block_if bus ();

    uart_rx_block #(
        .CLK_FREQ (44_000_000),
        .BAUD_RATE(230_400)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (bus)
    );

    always #5 clk = ~clk;

    // line[e] is the rx_in value captured by the e-th rising edge.
    always @(posedge clk) begin
        if (cyc < LINE_MAX) line[cyc] = bus.rx_in;
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.frame_err)) begin
            evq.push_back('{valid: bus.rx_valid, err: bus.frame_err, ev_cyc: cyc - 1,
                            data: bus.data});
            check_eq("valid_err_excl", 32'(bus.rx_valid & bus.frame_err), 0);
        end
    end

    // Value an ideal receiver reads off the line at capture index i.
    function automatic logic samp(input int i);
`ifdef UART_RX_MAJORITY_EN
        return (line[i] & line[i-1]) | (line[i] & line[i-2]) | (line[i-1] & line[i-2]);
`else
        return line[i];
`endif
    endfunction

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; glitch >= 0 inverts the line for that single cycle offset.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch,
                              output int t0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10 * CC; i++) begin
            bus.rx_in = bits[i / CC] ^ (i == glitch);
            @(negedge clk);
        end
    endtask

    // Bit k sits at line index t0+HALF+(k+1)*CC; the strobe follows the stop sample by
    // the two-flop sync delay.
    task automatic expect_frame(input int t0, output int got_cyc);
        logic [7:0] b;
        logic       stop;
        ev_t        ev;
        got_cyc = -1;
        if (samp(t0 + HALF)) return;
        for (int k = 0; k < 8; k++) b[k] = samp(t0 + HALF + (k + 1) * CC);
        stop = samp(t0 + HALF + 9 * CC);
        check_eq("event_present", 32'(evq.size() > 0), 1);
        if (evq.size() == 0) return;
        ev = evq.pop_front();
        got_cyc = ev.ev_cyc;
        if (stop) exp_data = b;
        check_eq("event_cycle", ev.ev_cyc, t0 + HALF + 2 + 9 * CC);
        check_eq("event_kind", {30'd0, ev.valid, ev.err}, stop ? 2 : 1);
        check_eq("event_data", ev.data, exp_data);
    endtask

    initial begin
        int t0, t1, c0, c1;
        logic [7:0] r;
        logic stop_ok;
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_data", bus.data, 0);
        check_eq("rst_valid", bus.rx_valid, 0);
        check_eq("rst_busy", bus.rx_busy, 0);
        check_eq("rst_err", bus.frame_err, 0);
        rst = 1'b0;
        idle(20);

        // Single 0xA5 on an idle line.
        send_frame(8'hA5, 1'b1, -1, t0);
        check_eq("a5_busy_after", bus.rx_busy, 0);
        expect_frame(t0, c0);
        check_eq("a5_latency", c0 - t0 + 1, 1817);
        check_eq("a5_data", bus.data, 8'hA5);
        check_eq("a5_single", evq.size(), 0);
        idle(30);

        // Back-to-back 0x00 then 0xFF.
        send_frame(8'h00, 1'b1, -1, t0);
        send_frame(8'hFF, 1'b1, -1, t1);
        idle(10);
        expect_frame(t0, c0);
        expect_frame(t1, c1);
        check_eq("b2b_spacing", c1 - c0, 1910);
        check_eq("b2b_data", bus.data, 8'hFF);
        check_eq("b2b_extra", evq.size(), 0);

        // 40-cycle low glitch: start rejected at mid-bit.
        t0 = cyc;
        bus.rx_in = 1'b0;
        repeat (40) @(negedge clk);
        idle(10);
        check_eq("glitch_busy_hi", bus.rx_busy, 1);
        idle(HALF - 45);
        check_eq("glitch_busy_lo", bus.rx_busy, 0);
        expect_frame(t0, c0);
        check_eq("glitch_no_event", evq.size(), 0);
        idle(50);

        // Framing error followed by a long break, then a clean frame.
        send_frame(8'h3C, 1'b0, -1, t0);
        bus.rx_in = 1'b0;
        repeat (3000) @(negedge clk);
        check_eq("break_busy", bus.rx_busy, 1);
        expect_frame(t0, c0);
        check_eq("break_data_kept", bus.data, 8'hFF);
        idle(5);
        check_eq("break_release", bus.rx_busy, 0);
        idle(20);
        send_frame(8'h11, 1'b1, -1, t0);
        idle(5);
        expect_frame(t0, c0);
        check_eq("after_break", bus.data, 8'h11);

        // Reset pulse in the middle of bit 4.
        r = 8'($urandom);
        for (int i = 0; i < 5 * CC + CC / 2; i++) begin
            bus.rx_in = (i < CC) ? 1'b0 : r[(i - CC) / CC];
            @(negedge clk);
        end
        rst = 1'b1;
        bus.rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_data", bus.data, 0);
        check_eq("midrst_valid", bus.rx_valid, 0);
        check_eq("midrst_busy", bus.rx_busy, 0);
        check_eq("midrst_err", bus.frame_err, 0);
        exp_data = 8'h00;
        idle(2 * CC);
        check_eq("midrst_no_event", evq.size(), 0);
        send_frame(8'h5A, 1'b1, -1, t0);
        idle(5);
        expect_frame(t0, c0);
        check_eq("after_rst", bus.data, 8'h5A);
        idle(20);

        // One-cycle high spike on the bit-2 sample point of 0x00.
        send_frame(8'h00, 1'b1, HALF + 3 * CC, t0);
        idle(5);
        expect_frame(t0, c0);
`ifdef UART_RX_MAJORITY_EN
        check_eq("spike_data", bus.data, 8'h00);
`else
        check_eq("spike_data", bus.data, 8'h04);
`endif
        idle(20);

        // Random bytes, occasional bad stop bit, random gaps.
        for (int n = 0; n < 8; n++) begin
            r = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(r, stop_ok, -1, t0);
            idle(stop_ok ? $urandom_range(0, 30) : $urandom_range(1, 30));
            expect_frame(t0, c0);
        end
        idle(10);
        check_eq("leftover_events", evq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
